// File: rtl/imm_split_encoder_pkg.sv
// Shared definitions for the immediate split encoder: beat kinds, FSM states
// and the "fits a sign-extended 16-bit field" test.
package imm_split_encoder_pkg;

  localparam int KIND_W = 2;

  typedef enum logic [KIND_W-1:0] {
    KIND_SINGLE = 2'd0,
    KIND_UPPER  = 2'd1,
    KIND_LOWER  = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // A constant fits when bits 31..15 are all copies of the 16-bit sign bit.
  function automatic logic fits_imm16(input logic [31:0] value);
    return (&value[31:15]) | ~(|value[31:15]);
  endfunction

endpackage

// File: rtl/imm_split_encoder_fit_check.sv
// Combinational split of a 32-bit constant into the fields the encoder needs.
// hi_adj pre-compensates for the sign extension the decoder applies to the
// low half, so (hi_adj << 16) + sext(lo) reproduces the constant mod 2^32.
module imm_fit_check
  import imm_split_encoder_pkg::*;
(
  input  logic [31:0] value,
  output logic        fit,
  output logic [15:0] hi_adj,
  output logic [15:0] lo
);

  assign fit    = fits_imm16(value);
  assign hi_adj = value[31:16] + {15'd0, value[15]};
  assign lo     = value[15:0];

endmodule

// File: rtl/imm_split_encoder.sv
// Encodes 32-bit constants into one SINGLE beat or an UPPER/LOWER beat pair of
// 16-bit immediates, with a single-entry output register and ready/valid on
// both sides. Counts how many constants went out each way.
module imm_split_encoder
  import imm_split_encoder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_imm,
  output logic [1:0]        out_kind,
  output logic              out_last,
  output logic [CNT_W-1:0]  single_cnt,
  output logic [CNT_W-1:0]  split_cnt
);

  state_e             state;
  state_e             state_next;
  logic [IMM_W-1:0]   imm_q;
  logic [IMM_W-1:0]   low_q;
  kind_e              kind_q;
  logic               last_q;
  logic               accept;
  logic               fire;
  logic               fit;
  logic [15:0]        hi_adj;
  logic [15:0]        lo;

  imm_fit_check u_fit_check (
    .value  (in_value),
    .fit    (fit),
    .hi_adj (hi_adj),
    .lo     (lo)
  );

  assign out_imm  = imm_q;
  assign out_kind = kind_q;
  assign out_last = last_q;

  // A new constant can enter when nothing is held or the final beat leaves now.
  assign in_ready = !out_valid || (out_ready && out_last);
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a held beat advances only on handshake; a leaving final beat
  // may be replaced by a freshly accepted constant in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (fire) begin
          if (!last_q)     state_next = ST_LOW;
          else if (accept) state_next = ST_EMIT;
          else             state_next = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (fire) begin
          if (accept) state_next = ST_EMIT;
          else        state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: a beat is valid in every state except IDLE.
  always_comb begin
    out_valid = (state != ST_IDLE);
  end

  // Beat holding register: load a new constant, or swap in the stored low
  // half once the UPPER beat has been taken; otherwise hold steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q  <= '0;
      low_q  <= '0;
      kind_q <= KIND_SINGLE;
      last_q <= 1'b0;
    end else if (accept) begin
      imm_q  <= fit ? lo : hi_adj;
      kind_q <= fit ? KIND_SINGLE : KIND_UPPER;
      last_q <= fit;
      low_q  <= lo;
    end else if (fire && !last_q) begin
      imm_q  <= low_q;
      kind_q <= KIND_LOWER;
      last_q <= 1'b1;
    end
  end

  // Saturating statistics, bumped when the final beat of a constant leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      single_cnt <= '0;
      split_cnt  <= '0;
    end else if (fire && last_q) begin
      if (kind_q == KIND_SINGLE) begin
        if (single_cnt != '1) single_cnt <= single_cnt + 1'b1;
      end else begin
        if (split_cnt != '1) split_cnt <= split_cnt + 1'b1;
      end
    end
  end

endmodule
